// File: rtl/muldiv_ctrl.sv
// HI/LO controller for MIPS-style multiply/divide: converts signed operands to magnitudes,
// sequences an external multiplier or divider, applies sign fix-up and owns HI/LO.
module muldiv_ctrl #(
    parameter int unsigned TIMEOUT = 63
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [1:0]  op_code,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        div_zero,
    output logic        eng_err,
    output logic        mul_start,
    output logic        div_start,
    output logic [31:0] eng_a,
    output logic [31:0] eng_b,
    input  logic        mul_done,
    input  logic [63:0] mul_prod,
    input  logic        div_done,
    input  logic [31:0] div_quot,
    input  logic [31:0] div_rem,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [1:0] OpMult = 2'b00;
    localparam logic [1:0] OpDiv  = 2'b10;

    typedef enum logic [1:0] {StIdle, StStart, StWait, StFix} state_e;

    state_e        state_q, state_d;
    logic [1:0]    op_q;
    logic          sign_a_q, sign_b_q;
    logic [31:0]   eng_a_q, eng_b_q;
    logic [63:0]   res_q;
    logic [CW-1:0] cnt_q;
    logic          div_zero_q, eng_err_q;
    logic [31:0]   hi_q, lo_q;

    logic        in_signed, dz, accept, done_sel, timeout_hit;
    logic [31:0] mag_a, mag_b, fix_hi, fix_lo;

    // MULT and DIV (op_code[0] == 0) are the signed flavours.
    assign in_signed   = ~op_code[0];
    assign dz          = op_valid && op_code[1] && (rt_val == '0);
    assign accept      = (state_q == StIdle) && op_valid && !dz;
    assign mag_a       = (in_signed && rs_val[31]) ? -rs_val : rs_val;
    assign mag_b       = (in_signed && rt_val[31]) ? -rt_val : rt_val;
    assign done_sel    = op_q[1] ? div_done : mul_done;
    assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StStart;
            StStart: state_d = StWait;
            StWait: begin
                if (done_sel) begin
                    state_d = StFix;
                end else if (timeout_hit) begin
                    state_d = StIdle;
                end
            end
            StFix:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Quotient sign follows sign(a)^sign(b); remainder sign follows the dividend.
    always_comb begin
        fix_hi = res_q[63:32];
        fix_lo = res_q[31:0];
        if (op_q == OpMult && (sign_a_q ^ sign_b_q)) begin
            {fix_hi, fix_lo} = -res_q;
        end else if (op_q == OpDiv) begin
            if (sign_a_q ^ sign_b_q) fix_lo = -res_q[31:0];
            if (sign_a_q) fix_hi = -res_q[63:32];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            op_q       <= '0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            eng_a_q    <= '0;
            eng_b_q    <= '0;
            res_q      <= '0;
            cnt_q      <= '0;
            div_zero_q <= 1'b0;
            eng_err_q  <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            div_zero_q <= (state_q == StIdle) && dz;
            eng_err_q  <= (state_q == StWait) && !done_sel && timeout_hit;
            if (accept) begin
                op_q     <= op_code;
                sign_a_q <= in_signed & rs_val[31];
                sign_b_q <= in_signed & rt_val[31];
                eng_a_q  <= mag_a;
                eng_b_q  <= mag_b;
            end
            if (state_q == StStart) begin
                cnt_q <= '0;
            end else if (state_q == StWait) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (state_q == StWait && done_sel) begin
                res_q <= op_q[1] ? {div_rem, div_quot} : mul_prod;
            end
            // MTHI/MTLO land in IDLE; a result in FIX overwrites any such write.
            if (state_q == StFix) begin
                hi_q <= fix_hi;
                lo_q <= fix_lo;
            end else if (state_q == StIdle) begin
                if (hi_we) hi_q <= wdata;
                if (lo_we) lo_q <= wdata;
            end
        end
    end

    assign busy      = (state_q != StIdle);
    assign mul_start = (state_q == StStart) && !op_q[1];
    assign div_start = (state_q == StStart) && op_q[1];
    assign eng_a     = eng_a_q;
    assign eng_b     = eng_b_q;
    assign div_zero  = div_zero_q;
    assign eng_err   = eng_err_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 63, maximum WAIT cycles allowed before engine completion is declared lost.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 op_valid  in  1  CPU issues a HI/LO operation this cycle.
REQ-005 op_code  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 rs_val  in  32  first operand (multiplicand or dividend).
REQ-007 rt_val  in  32  second operand (multiplier or divisor).
REQ-008 hi_we, lo_we  in  1 each  MTHI/MTLO write strobes.
REQ-009 wdata  in  32  MTHI/MTLO write data.
REQ-010 busy  out  1  operation in flight; CPU stalls HI/LO consumers.
REQ-011 div_zero  out  1  one-cycle pulse, divide by zero rejected.
REQ-012 eng_err  out  1  one-cycle pulse, engine timeout.
REQ-013 mul_start, div_start  out  1 each  one-cycle engine start pulses.
REQ-014 eng_a, eng_b  out  32 each  unsigned operand magnitudes to engines.
REQ-015 mul_done  in  1, mul_prod  in  64  multiplier completion and unsigned product.
REQ-016 div_done  in  1, div_quot  in  32, div_rem  in  32  divider completion, unsigned quotient and remainder.
REQ-017 HI, LO  out  32 each  architectural HI/LO registers.

Function
REQ-018 FSM states IDLE, START, WAIT, FIX; IDLE is the only state with busy=0.
REQ-019 IDLE: op_valid=1 and not divide-by-zero -> latch op_code, operand signs, magnitudes; next state START.
REQ-020 Magnitude: signed ops (MULT, DIV) use two's-complement absolute value (0x80000000 -> 0x80000000); unsigned ops pass operands unchanged.
REQ-021 START: exactly one of mul_start/div_start high for one cycle per op_code; next state WAIT.
REQ-022 eng_a/eng_b hold the latched magnitudes from START through FIX.
REQ-023 WAIT: only the done of the engine started is sampled; the other engine's done is ignored; done in START is ignored.
REQ-024 WAIT: on done, capture result, next state FIX; wait counter increments per WAIT cycle.
REQ-025 WAIT: counter reaching TIMEOUT without done -> eng_err pulse, HI/LO unchanged, next state IDLE.
REQ-026 FIX: MULT -> 64-bit product negated if operand signs differ; {HI,LO} = result.
REQ-027 FIX: DIV -> LO = quotient negated if signs differ; HI = remainder negated if dividend negative.
REQ-028 FIX: MULTU/DIVU -> engine results written unmodified (HI=prod[63:32]/rem, LO=prod[31:0]/quot).
REQ-029 HI/LO update at the edge ending FIX; next state IDLE; busy low the following cycle.
REQ-030 Divide by zero: IDLE, op_valid, op_code DIV/DIVU, rt_val=0 -> no start, HI/LO unchanged, div_zero pulse next cycle, stay IDLE.
REQ-031 op_valid while busy=1 is ignored (no queuing).
REQ-032 hi_we/lo_we honoured only in IDLE; ignored while busy.
REQ-033 hi_we/lo_we simultaneous with accepted op_valid: write applies that edge; operation result later overwrites.
REQ-034 Latency: accept at edge N, mul_start/div_start during cycle N+1, HI/LO valid after engine latency + 2 cycles.

Reset
REQ-035 reset=1: state IDLE, HI=LO=0, busy=0, starts=0, div_zero=0, eng_err=0, wait counter 0, eng_a=eng_b=0.
REQ-036 reset mid-operation aborts it; engine done arriving after reset is ignored.

Verification
REQ-037 DIV rs=0xFFFFFFF9, rt=2; engine sees a=7, b=2, returns quot=3 rem=1 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-038 MULT rs=0xFFFFFFFD, rt=5; engine sees a=3, b=5, returns 15 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
REQ-039 DIVU rs=10, rt=0 with HI=LO=0x1234 -> div_zero one pulse, no start, busy stays 0, HI/LO=0x1234.
REQ-040 MULTU, engine never asserts done, TIMEOUT=63 -> eng_err after 63 WAIT cycles, back to IDLE, HI/LO unchanged.
REQ-041 reset asserted in WAIT, then div_done=1 with quot=9 -> HI=LO=0, busy=0, no update.
REQ-042 Busy MULT, then op_valid DIV and hi_we wdata=0xAA -> both ignored; only MULT result lands in HI/LO.
